// File: rtl/gwct_cmd_arbiter_if.sv
// gwct_cmd_arbiter_if: requester, response and APB command signals of the command arbiter
interface gwct_cmd_arbiter_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0]    req_valid, req_lock, req_write, req_done;
  logic [32*N_REQ-1:0] req_addr, req_wdata;
  logic [31:0]         rsp_rdata, cmd_addr, cmd_wdata, cmd_rdata;
  logic                rsp_error, busy, cmd_valid, cmd_write, cmd_ready, cmd_error;
  logic [2:0]          grant;
  modport slave (
    input  req_valid, req_lock, req_write, req_addr, req_wdata, cmd_ready, cmd_rdata, cmd_error,
    output req_done, rsp_rdata, rsp_error, grant, busy, cmd_valid, cmd_addr, cmd_wdata, cmd_write
  );
  modport master (
    output req_valid, req_lock, req_write, req_addr, req_wdata, cmd_ready, cmd_rdata, cmd_error,
    input  req_done, rsp_rdata, rsp_error, grant, busy, cmd_valid, cmd_addr, cmd_wdata, cmd_write
  );
endinterface

// File: rtl/gwct_cmd_arbiter.sv
// gwct_cmd_arbiter: round-robin sharing of one APB command port with bounded per-requester lock
module gwct_cmd_arbiter #(
  parameter int N_REQ    = 2,
  parameter int LOCK_MAX = 16
) (
  input logic             clk,
  input logic             rst,
  gwct_cmd_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_e;
  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, grant_q, lock_owner_q, win, cand;
  logic            lock_vld_q, lock_ok, found;
  logic [CW-1:0]   lock_cnt_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic            write_q, error_q;
  // A live, unexhausted lock wins outright; otherwise search starts just after the last owner
  always_comb begin
    lock_ok = lock_vld_q && bus.req_valid[lock_owner_q] && lock_cnt_q < CW'(LOCK_MAX);
    found   = lock_ok;
    win     = lock_owner_q;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == ARB)   ? (found ? ISSUE : ARB) :
              (state_q == ISSUE) ? WAIT :
              (state_q == WAIT)  ? (bus.cmd_ready ? RESP : WAIT) : ARB;
  end
  always_comb begin
    bus.cmd_valid = state_q == ISSUE;
    bus.busy      = state_q != ARB;
    bus.req_done  = (state_q == RESP) ? N_REQ'(1) << grant_q : '0;
    bus.grant     = 3'(grant_q);
    bus.cmd_addr  = addr_q;
    bus.cmd_wdata = wdata_q;
    bus.cmd_write = write_q;
    bus.rsp_rdata = rdata_q;
    bus.rsp_error = error_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= IW'(N_REQ - 1);
      grant_q      <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      if (state_q == ARB && found) begin
        addr_q       <= bus.req_addr[32*win +: 32];
        wdata_q      <= bus.req_wdata[32*win +: 32];
        write_q      <= bus.req_write[win];
        grant_q      <= win;
        rr_q         <= win;
        lock_owner_q <= win;
        lock_vld_q   <= bus.req_lock[win];
        lock_cnt_q   <= bus.req_lock[win] ? (lock_ok ? lock_cnt_q + 1'b1 : CW'(1)) : '0;
      end else if (state_q == ARB) begin
        lock_vld_q <= 1'b0;
        lock_cnt_q <= '0;
      end
      if (state_q == WAIT && bus.cmd_ready) begin
        rdata_q <= bus.cmd_rdata;
        error_q <= bus.cmd_error;
      end
    end
  end
endmodule

// File: tb/tb_gwct_cmd_arbiter.sv
// tb_gwct_cmd_arbiter: table-driven requester agents, APB slave model and scoreboard for the arbiter
module tb_gwct_cmd_arbiter;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gwct_cmd_arbiter_if #(.N_REQ(N)) bus();
  gwct_cmd_arbiter #(.N_REQ(N), .LOCK_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {int tst; int rq; logic wr; logic lk; logic [31:0] addr; logic [31:0] wdata;} vec_t;
  typedef struct {logic wr; logic lk; logic [31:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {logic [2:0] g; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic err;} exp_t;

  vec_t tbl[$];
  req_t rq0[$], rq1[$];
  exp_t sb[$];
  int n_chk = 0, n_pass = 0, done_cnt = 0, slv_lat = 0, rst_age = 0;
  logic cmd_prev = 1'b0, rdy_seen = 1'b0;
  logic [N-1:0] v_prev = '0, done_last = '0;
  logic [31:0] slv_a;
  int slv_n;
  bit slv_abort;

  function automatic logic [31:0] slv_rdata(logic [31:0] a);
    return {16'h0, a[15:0]};
  endfunction
  function automatic logic slv_err(logic [31:0] a);
    return a == 32'hFFFF_0000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic submit(vec_t v);
    req_t r;
    exp_t e;
    r = '{wr: v.wr, lk: v.lk, addr: v.addr, wdata: v.wdata};
    if (v.rq == 0) rq0.push_back(r);
    else rq1.push_back(r);
    e = '{g: 3'(v.rq), wr: v.wr, addr: v.addr, wdata: v.wdata, rdata: slv_rdata(v.addr), err: slv_err(v.addr)};
    sb.push_back(e);
  endtask

  task automatic wait_drain(string nm);
    int c = 0;
    while (sb.size() > 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(nm, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rq0.delete();
    rq1.delete();
    sb.delete();
    @(negedge clk);
    check("rst_done",  32'(bus.req_done), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_cmd",   {31'd0, bus.cmd_valid | bus.cmd_write | (|bus.cmd_addr) | (|bus.cmd_wdata)}, 32'd0);
    check("rst_rsp",   bus.rsp_rdata | 32'(bus.rsp_error), 32'd0);
    rst = 1'b0;
  endtask

  // Requester agents: present queue head, advance on req_done
  initial begin
    bus.req_valid = '0; bus.req_lock = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.req_done[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (bus.req_done[1] && rq1.size() > 0) void'(rq1.pop_front());
      bus.req_valid[0] = !rst && rq0.size() > 0;
      bus.req_valid[1] = !rst && rq1.size() > 0;
      if (rq0.size() > 0) begin
        bus.req_write[0] = rq0[0].wr; bus.req_lock[0] = rq0[0].lk;
        bus.req_addr[31:0] = rq0[0].addr; bus.req_wdata[31:0] = rq0[0].wdata;
      end
      if (rq1.size() > 0) begin
        bus.req_write[1] = rq1[0].wr; bus.req_lock[1] = rq1[0].lk;
        bus.req_addr[63:32] = rq1[0].addr; bus.req_wdata[63:32] = rq1[0].wdata;
      end
    end
  end

  // APB slave model: completes each command after a latency, aborts on reset
  initial begin
    bus.cmd_ready = 1'b0; bus.cmd_rdata = '0; bus.cmd_error = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cmd_valid && !rst) begin
        slv_a = bus.cmd_addr;
        slv_n = (slv_lat > 0) ? slv_lat : int'($urandom_range(1, 3));
        slv_abort = 1'b0;
        for (int c = 0; c < slv_n && !slv_abort; c++) begin
          @(negedge clk);
          slv_abort = rst;
        end
        if (!slv_abort) begin
          bus.cmd_ready = 1'b1; bus.cmd_rdata = slv_rdata(slv_a); bus.cmd_error = slv_err(slv_a);
          @(negedge clk);
          bus.cmd_ready = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor on the falling edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.cmd_valid) begin
        if (sb.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
        else begin
          check("cmd_addr",  bus.cmd_addr, sb[0].addr);
          check("cmd_wdata", bus.cmd_wdata, sb[0].wdata);
          check("cmd_write", 32'(bus.cmd_write), 32'(sb[0].wr));
          check("cmd_grant", 32'(bus.grant), 32'(sb[0].g));
          check("cmd_busy",  32'(bus.busy), 32'd1);
        end
        check("cmd_single", 32'(cmd_prev), 32'd0);
      end
      if (bus.req_done != '0) begin
        done_cnt++;
        if (sb.size() == 0) check("done_unexpected", 32'(bus.req_done), 32'd0);
        else begin
          check("done_onehot", 32'(bus.req_done), 32'd1 << sb[0].g);
          check("rsp_rdata",   bus.rsp_rdata, sb[0].rdata);
          check("rsp_error",   32'(bus.rsp_error), 32'(sb[0].err));
          check("done_latency", 32'(rdy_seen), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
    cmd_prev = bus.cmd_valid;
    done_last = bus.req_done;
  end

  // Requesters must hold req_valid until their req_done
  initial forever begin
    @(posedge clk);
    rdy_seen = bus.cmd_ready;
    if (rst) rst_age = 0;
    else if (rst_age < 4) rst_age++;
    for (int i = 0; i < N; i++)
      if (rst_age >= 4 && v_prev[i] && !bus.req_valid[i])
        check($sformatf("valid_hold%0d", i), 32'(done_last[i]), 32'd1);
    v_prev = bus.req_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc0;
    tbl.push_back('{tst: 1, rq: 0, wr: 1'b1, lk: 1'b0, addr: 32'h1000_0010, wdata: 32'hDEADBEEF});
    tbl.push_back('{tst: 2, rq: 0, wr: 1'b0, lk: 1'b0, addr: 32'h0000_0011, wdata: 32'h0});
    tbl.push_back('{tst: 2, rq: 1, wr: 1'b0, lk: 1'b0, addr: 32'h2000_0022, wdata: 32'h0});
    for (int k = 0; k < 6; k++)
      tbl.push_back('{tst: 3, rq: k % 2, wr: k[0], lk: 1'b0, addr: 32'h3000_0100 + 32'(k), wdata: 32'hA5A5_0000 + 32'(k)});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{tst: 4, rq: 0, wr: 1'b1, lk: 1'b1, addr: 32'h4000_0000 + 32'(k * 16), wdata: 32'(k)});
    tbl.push_back('{tst: 4, rq: 1, wr: 1'b0, lk: 1'b0, addr: 32'h4100_0044, wdata: 32'h0});
    tbl.push_back('{tst: 4, rq: 0, wr: 1'b0, lk: 1'b0, addr: 32'h4000_0050, wdata: 32'h0});
    tbl.push_back('{tst: 5, rq: 0, wr: 1'b0, lk: 1'b0, addr: 32'hFFFF_0000, wdata: 32'h0});
    tbl.push_back('{tst: 5, rq: 0, wr: 1'b0, lk: 1'b0, addr: 32'h5000_0055, wdata: 32'h0});

    repeat (3) @(negedge clk);
    do_reset();
    for (int t = 1; t <= 5; t++) begin
      if (t == 2) do_reset();
      @(negedge clk);
      foreach (tbl[i]) if (tbl[i].tst == t) submit(tbl[i]);
      wait_drain($sformatf("drain_t%0d", t));
      @(negedge clk);
      check($sformatf("idle_busy_t%0d", t), 32'(bus.busy), 32'd0);
    end
    check("grant_hold", 32'(bus.grant), 32'd0);

    // Reset while waiting on the APB slave abandons the transfer
    slv_lat = 8;
    @(negedge clk);
    submit('{tst: 6, rq: 0, wr: 1'b0, lk: 1'b0, addr: 32'h6000_0066, wdata: 32'h0});
    for (int c = 0; c < 50 && !bus.cmd_valid; c++) @(negedge clk);
    check("t6_issue", 32'(bus.cmd_valid), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_wait_busy", 32'(bus.busy), 32'd1);
    dc0 = done_cnt;
    do_reset();
    slv_lat = 0;
    repeat (10) @(negedge clk);
    check("t6_no_done", 32'(done_cnt), 32'(dc0));
    check("t6_idle", 32'(bus.busy), 32'd0);
    submit('{tst: 6, rq: 1, wr: 1'b1, lk: 1'b0, addr: 32'h6100_0077, wdata: 32'h1234_5678});
    wait_drain("drain_t6");
    check("t6_grant", 32'(bus.grant), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
